// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and timing defaults for the SRAM macro controller
//
// Holds the controller state enum, the default phase lengths and two small
// helpers used to derive effective phase lengths and counter widths.
package sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_RECOV = 3'd3,
    ST_RESP  = 3'd4
  } sram_state_e;

  localparam int DEF_T_SETUP = 1;
  localparam int DEF_T_PULSE = 2;
  localparam int DEF_T_RECOV = 1;

  // A zero-length phase would let strobes collapse into their neighbours,
  // so every phase lasts at least one cycle.
  function automatic int min1(input int t);
    return (t < 1) ? 1 : t;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - loadable saturating down-counter timing one FSM phase
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - reload the counter (asserted on every state entry)
//   load_val    - phase length minus one
//   done        - counter has reached zero; the current phase ends this cycle
module sram_phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  // Saturates at zero so a long-running state never wraps into a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - request/response sequencer driving an SRAM macro's wordlines, precharge and sense amps
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   req_valid/req_ready        - request handshake (ready only in IDLE)
//   req_we/req_addr/req_wdata  - operation, row address, write data
//   rsp_valid                  - one-cycle completion pulse
//   rsp_rdata/rsp_err          - read data (0 for writes/errors), address error
//   data_in                    - write driver data
//   row_wr/row_rd              - one-hot write/read wordlines
//   pre_en/sa_en               - bitline precharge, sense-amp enable
//   preout                     - sense-amp outputs
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 1,
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_RECOV = DEF_T_RECOV,
  localparam int AW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [COLS-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [COLS-1:0] data_in,
  output logic [ROWS-1:0] row_wr,
  output logic [ROWS-1:0] row_rd,
  output logic            pre_en,
  output logic            sa_en,
  input  logic [COLS-1:0] preout
);

  localparam int TS   = min1(T_SETUP);
  localparam int TP   = min1(T_PULSE);
  localparam int TR   = min1(T_RECOV);
  localparam int TMAX = max3(TS, TP, TR);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  sram_state_e     state_q, state_n;
  logic            accept, addr_bad;
  logic            op_we_q, op_we_n;
  logic            op_err_q, op_err_n;
  logic [AW-1:0]   op_addr_q, op_addr_n;
  logic [COLS-1:0] op_wdata_q, op_wdata_n;

  logic            phase_load, phase_done;
  logic [TW-1:0]   phase_len;

  logic            req_ready_d, rsp_valid_d, rsp_err_d, pre_en_d, sa_en_d;
  logic [COLS-1:0] data_in_d;
  logic [ROWS-1:0] row_wr_d, row_rd_d;

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign addr_bad = int'(req_addr) >= ROWS;

  // Request fields as they will be after this edge; the output decode needs
  // them on the accept cycle, before the operand registers have loaded.
  always_comb begin
    op_we_n    = op_we_q;
    op_err_n   = op_err_q;
    op_addr_n  = op_addr_q;
    op_wdata_n = op_wdata_q;
    if (accept) begin
      op_we_n    = req_we;
      op_err_n   = addr_bad;
      op_addr_n  = req_addr;
      op_wdata_n = req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_we_q    <= 1'b0;
      op_err_q   <= 1'b0;
      op_addr_q  <= '0;
      op_wdata_q <= '0;
    end else begin
      state_q    <= state_n;
      op_we_q    <= op_we_n;
      op_err_q   <= op_err_n;
      op_addr_q  <= op_addr_n;
      op_wdata_q <= op_wdata_n;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_IDLE:  if (req_valid) state_n = addr_bad ? ST_RESP : ST_SETUP;
      ST_SETUP: if (phase_done) state_n = ST_PULSE;
      ST_PULSE: if (phase_done) state_n = ST_RECOV;
      ST_RECOV: if (phase_done) state_n = ST_RESP;
      ST_RESP:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // The timer reloads on every state change with the length of the state
  // being entered, so its done flag marks the last cycle of that phase.
  assign phase_load = (state_n != state_q);

  always_comb begin
    phase_len = '0;
    case (state_n)
      ST_SETUP: phase_len = TW'(TS - 1);
      ST_PULSE: phase_len = TW'(TP - 1);
      ST_RECOV: phase_len = TW'(TR - 1);
      default:  phase_len = '0;
    endcase
  end

  sram_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (phase_load),
    .load_val (phase_len),
    .done     (phase_done)
  );

  // Strobes are decoded from the next state and registered, so every macro
  // control pin comes straight off a flop.
  always_comb begin
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    pre_en_d    = 1'b0;
    sa_en_d     = 1'b0;
    data_in_d   = '0;
    row_wr_d    = '0;
    row_rd_d    = '0;
    case (state_n)
      ST_IDLE:  req_ready_d = 1'b1;
      ST_SETUP: begin
        if (op_we_n) data_in_d = op_wdata_n;
        else         pre_en_d  = 1'b1;
      end
      ST_PULSE: begin
        if (op_we_n) begin
          data_in_d = op_wdata_n;
          row_wr_d  = ROWS'(1) << op_addr_n;
        end else begin
          row_rd_d  = ROWS'(1) << op_addr_n;
          sa_en_d   = 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = op_err_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      pre_en    <= 1'b0;
      sa_en     <= 1'b0;
      data_in   <= '0;
      row_wr    <= '0;
      row_rd    <= '0;
    end else begin
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      pre_en    <= pre_en_d;
      sa_en     <= sa_en_d;
      data_in   <= data_in_d;
      row_wr    <= row_wr_d;
      row_rd    <= row_rd_d;
    end
  end

  // Cleared on accept so writes and address errors report zero; sampled at
  // the end of the final read pulse while the sense amps are still enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
    end else if (accept) begin
      rsp_rdata <= '0;
    end else if (state_q == ST_PULSE && phase_done && !op_we_q) begin
      rsp_rdata <= preout;
    end
  end

endmodule
